bank_arbiter: RTL and testbench

Two-port arbiter and sequencer for the four-bank memory array. Each port issues a read or write; the block decodes the bank from the top two address bits, resolves same-bank conflicts with a round-robin pointer, and drives registered per-bank command lines. Read data is routed back to the originating port with fixed latency. It sits between the requester ports and the four single-port banks.

---
 rtl/bank_arb_pkg.sv | 33 +++
 rtl/bank_arbiter_if.sv | 36 +++
 rtl/bank_rsp_pipe.sv | 37 +++
 rtl/bank_arbiter.sv | 115 +++++++++++
 tb/tb_bank_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_arb_pkg.sv
// Shared types and helpers for the four-bank arbiter.
package bank_arb_pkg;

   localparam int NUM_BANKS  = 4;
   localparam int BANK_SEL_W = 2;

   typedef logic [BANK_SEL_W-1:0] bank_sel_t;
   typedef logic [NUM_BANKS-1:0]  bank_vec_t;

   // Requester identity; also the encoding of the round-robin pointer.
   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_id_e;

   // Response-pipe tag: which bank slot to pick read data from.
   typedef struct packed {
      logic      valid;
      bank_sel_t slot;
   } rsp_tag_t;

   // Bank select to one-hot enable: sel 00 -> 4'b1000, sel 11 -> 4'b0001.
   function automatic bank_vec_t bank_onehot(input bank_sel_t sel);
      return {1'b1, {(NUM_BANKS-1){1'b0}}} >> sel;
   endfunction

   // Bank select to bus slot index. Slot k lines up with enable bit k, so
   // slot = 3 - sel, which for a 2-bit select is the bitwise inverse.
   function automatic bank_sel_t bank_slot(input bank_sel_t sel);
      return ~sel;
   endfunction

endpackage

// File: rtl/bank_arbiter_if.sv
// Requester-side handshake, request and response signals for ports A and B.
interface bank_arbiter_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8
);
   logic                  i_a_valid;
   logic                  i_b_valid;
   logic                  o_a_ready;
   logic                  o_b_ready;
   logic                  i_a_wr;
   logic                  i_b_wr;
   logic [ADDR_WIDTH-1:0] i_a_addr;
   logic [ADDR_WIDTH-1:0] i_b_addr;
   logic [DATA_WIDTH-1:0] i_a_wdata;
   logic [DATA_WIDTH-1:0] i_b_wdata;
   logic                  o_a_rvalid;
   logic                  o_b_rvalid;
   logic [DATA_WIDTH-1:0] o_a_rdata;
   logic [DATA_WIDTH-1:0] o_b_rdata;

   // Arbiter side.
   modport slave (
      input  i_a_valid, i_b_valid, i_a_wr, i_b_wr,
      input  i_a_addr, i_b_addr, i_a_wdata, i_b_wdata,
      output o_a_ready, o_b_ready,
      output o_a_rvalid, o_b_rvalid, o_a_rdata, o_b_rdata
   );

   // Requester side.
   modport master (
      output i_a_valid, i_b_valid, i_a_wr, i_b_wr,
      output i_a_addr, i_b_addr, i_a_wdata, i_b_wdata,
      input  o_a_ready, o_b_ready,
      input  o_a_rvalid, o_b_rvalid, o_a_rdata, o_b_rdata
   );
endinterface

// File: rtl/bank_rsp_pipe.sv
// Per-port read response pipe: two tag stages track the bank access, then the
// tagged bank's read data is captured into the port's output register.
module bank_rsp_pipe
   import bank_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_push,
   input  bank_sel_t                       i_slot,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] i_bank_rdata,
   output logic                            o_rvalid,
   output logic [DATA_WIDTH-1:0]           o_rdata
);

   rsp_tag_t s1_q;
   rsp_tag_t s2_q;

   // Shift tags along with the bank access; capture data when the tag is live.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_q     <= '0;
         s2_q     <= '0;
         o_rvalid <= 1'b0;
         o_rdata  <= '0;
      end else begin
         s1_q     <= '{valid: i_push, slot: i_slot};
         s2_q     <= s1_q;
         o_rvalid <= s2_q.valid;
         if (s2_q.valid) begin
            o_rdata <= i_bank_rdata[s2_q.slot*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/bank_arbiter.sv
// Two-port arbiter/sequencer for four single-port banks: decodes the bank
// from the top address bits, resolves same-bank conflicts round-robin and
// drives registered per-bank commands; read data returns after 3 cycles.
module bank_arbiter
   import bank_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                                       i_clk,
   input  logic                                       i_rst_n,
   bank_arbiter_if.slave                              req,
   output logic [NUM_BANKS-1:0]                       o_bank_en,
   output logic [NUM_BANKS-1:0]                       o_bank_we,
   output logic [NUM_BANKS*(ADDR_WIDTH-BANK_SEL_W)-1:0] o_bank_addr,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]            o_bank_wdata,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0]            i_bank_rdata,
   output logic [CNT_WIDTH-1:0]                       o_conflict_cnt
);

   localparam int WORD_W = ADDR_WIDTH - BANK_SEL_W;

   bank_sel_t a_sel;
   bank_sel_t b_sel;
   logic      conflict;
   logic      a_acc;
   logic      b_acc;
   bank_vec_t a_hit;
   bank_vec_t b_hit;
   port_id_e  prio_q;
   port_id_e  prio_d;

   assign a_sel    = req.i_a_addr[ADDR_WIDTH-1 -: BANK_SEL_W];
   assign b_sel    = req.i_b_addr[ADDR_WIDTH-1 -: BANK_SEL_W];
   assign conflict = req.i_a_valid & req.i_b_valid & (a_sel == b_sel);
   assign a_acc    = req.i_a_valid & req.o_a_ready;
   assign b_acc    = req.i_b_valid & req.o_b_ready;
   assign a_hit    = a_acc ? bank_onehot(a_sel) : '0;
   assign b_hit    = b_acc ? bank_onehot(b_sel) : '0;

   // Priority pointer register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      if (!i_rst_n) prio_q <= PORT_A;
      else          prio_q <= prio_d;
   end

   // Next priority: a conflict hands priority to the port that just lost.
   always_comb begin
      // NOTE: default first so every path assigns prio_d and no latch forms.
      prio_d = prio_q;
      if (conflict) prio_d = (prio_q == PORT_A) ? PORT_B : PORT_A;
   end

   // Ready outputs: only the losing side of a conflict is held off.
   always_comb begin
      req.o_a_ready = !(conflict && prio_q == PORT_B);
      req.o_b_ready = !(conflict && prio_q == PORT_A);
   end

   // Per-bank command registers; at most one port hits a given bank.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: address/data registers are reset as well, so the bank bus
         // is all-zero after reset rather than holding stale values.
         o_bank_en    <= '0;
         o_bank_we    <= '0;
         o_bank_addr  <= '0;
         o_bank_wdata <= '0;
      end else begin
         for (int k = 0; k < NUM_BANKS; k++) begin
            o_bank_en[k] <= a_hit[k] | b_hit[k];
            o_bank_we[k] <= (a_hit[k] & req.i_a_wr) | (b_hit[k] & req.i_b_wr);
            if (a_hit[k]) begin
               o_bank_addr[k*WORD_W +: WORD_W]         <= req.i_a_addr[WORD_W-1:0];
               o_bank_wdata[k*DATA_WIDTH +: DATA_WIDTH] <= req.i_a_wdata;
            end else if (b_hit[k]) begin
               o_bank_addr[k*WORD_W +: WORD_W]         <= req.i_b_addr[WORD_W-1:0];
               o_bank_wdata[k*DATA_WIDTH +: DATA_WIDTH] <= req.i_b_wdata;
            end
         end
      end
   end

   // Saturating count of conflict cycles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_conflict_cnt <= '0;
      end else if (conflict && o_conflict_cnt != '1) begin
         o_conflict_cnt <= o_conflict_cnt + 1'b1;
      end
   end

   bank_rsp_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_a_rsp (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_push       (a_acc & ~req.i_a_wr),
      .i_slot       (bank_slot(a_sel)),
      .i_bank_rdata (i_bank_rdata),
      .o_rvalid     (req.o_a_rvalid),
      .o_rdata      (req.o_a_rdata)
   );

   bank_rsp_pipe #(.DATA_WIDTH(DATA_WIDTH)) u_b_rsp (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_push       (b_acc & ~req.i_b_wr),
      .i_slot       (bank_slot(b_sel)),
      .i_bank_rdata (i_bank_rdata),
      .o_rvalid     (req.o_b_rvalid),
      .o_rdata      (req.o_b_rdata)
   );

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter with a behavioural four-bank memory model.
// Built with a 4-bit conflict counter so saturation is reachable quickly.
module tb_bank_arbiter;

   localparam int AW = 6;
   localparam int DW = 8;
   localparam int WW = AW - 2;
   localparam int CW = 4;

   logic            clk;
   logic            rst_n;
   logic            mem_load;
   logic [3:0]      bank_en;
   logic [3:0]      bank_we;
   logic [4*WW-1:0] bank_addr;
   logic [4*DW-1:0] bank_wdata;
   logic [4*DW-1:0] bank_rdata;
   logic [CW-1:0]   conflict_cnt;
   logic [DW-1:0]   mem [4][16];

   int n_checks = 0;
   int n_errors = 0;

   bank_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) req ();

   bank_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .req            (req),
      .o_bank_en      (bank_en),
      .o_bank_we      (bank_we),
      .o_bank_addr    (bank_addr),
      .o_bank_wdata   (bank_wdata),
      .i_bank_rdata   (bank_rdata),
      .o_conflict_cnt (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank model: slot k holds bank select 3-k; initial word w of slot k is
   // {sel, 2'b10, w}. Read data appears the cycle after the enable.
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (mem_load) begin
            for (int w = 0; w < 16; w++) mem[k][w] <= {2'(3 - k), 2'b10, 4'(w)};
         end else if (bank_en[k]) begin
            if (bank_we[k]) mem[k][bank_addr[k*WW +: WW]] <= bank_wdata[k*DW +: DW];
            else            bank_rdata[k*DW +: DW]      <= mem[k][bank_addr[k*WW +: WW]];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req.i_a_valid = 1'b0;
      req.i_b_valid = 1'b0;
      req.i_a_wr    = 1'b0;
      req.i_b_wr    = 1'b0;
      req.i_a_addr  = '0;
      req.i_b_addr  = '0;
      req.i_a_wdata = '0;
      req.i_b_wdata = '0;
   endtask

   task automatic drive_a(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      req.i_a_valid = 1'b1;
      req.i_a_wr    = wr;
      req.i_a_addr  = addr;
      req.i_a_wdata = wdata;
   endtask

   task automatic drive_b(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      req.i_b_valid = 1'b1;
      req.i_b_wr    = wr;
      req.i_b_addr  = addr;
      req.i_b_wdata = wdata;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_bank_en"},    32'(bank_en),          32'h0);
      check({pfx, "_bank_we"},    32'(bank_we),          32'h0);
      check({pfx, "_bank_addr"},  32'(bank_addr),        32'h0);
      check({pfx, "_bank_wdata"}, bank_wdata,            32'h0);
      check({pfx, "_a_rvalid"},   32'(req.o_a_rvalid),   32'h0);
      check({pfx, "_b_rvalid"},   32'(req.o_b_rvalid),   32'h0);
      check({pfx, "_a_rdata"},    32'(req.o_a_rdata),    32'h0);
      check({pfx, "_b_rdata"},    32'(req.o_b_rdata),    32'h0);
      check({pfx, "_cnt"},        32'(conflict_cnt),     32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] rr_addr [4];
      logic [DW-1:0] rr_data [4];
      rr_addr = '{6'h10, 6'h21, 6'h32, 6'h03};
      rr_data = '{8'h11, 8'hA1, 8'hE2, 8'h23};

      rst_n    = 1'b0;
      mem_load = 1'b1;
      idle();
      tick();
      mem_load = 1'b0;

      // Reset state, and priority starts at A (visible through ready).
      check_reset_outputs("rst");
      drive_a(1'b0, 6'h10, 8'h00);
      drive_b(1'b0, 6'h14, 8'h00);
      #1;
      check("rst_a_ready", 32'(req.o_a_ready), 32'h1);
      check("rst_b_ready", 32'(req.o_b_ready), 32'h0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single write then read on bank sel 00 (slot 3).
      drive_a(1'b1, 6'h05, 8'hA5);
      #1;
      check("t1_wr_ready", 32'(req.o_a_ready), 32'h1);
      tick();
      check("t1_wr_en",    32'(bank_en),             32'h8);
      check("t1_wr_we",    32'(bank_we),             32'h8);
      check("t1_wr_addr",  32'(bank_addr[15:12]),    32'h5);
      check("t1_wr_wdata", 32'(bank_wdata[31:24]),   32'hA5);
      drive_a(1'b0, 6'h05, 8'h00);
      tick();
      check("t1_rd_en", 32'(bank_en), 32'h8);
      check("t1_rd_we", 32'(bank_we), 32'h0);
      idle();
      tick();
      check("t1_rvalid_early", 32'(req.o_a_rvalid), 32'h0);
      tick();
      check("t1_rvalid", 32'(req.o_a_rvalid), 32'h1);
      check("t1_rdata",  32'(req.o_a_rdata),  32'hA5);
      check("t1_b_rvalid", 32'(req.o_b_rvalid), 32'h0);
      tick();

      // Simultaneous reads to different banks are both accepted.
      drive_a(1'b0, 6'h00, 8'h00);
      drive_b(1'b0, 6'h3F, 8'h00);
      #1;
      check("t2_a_ready", 32'(req.o_a_ready), 32'h1);
      check("t2_b_ready", 32'(req.o_b_ready), 32'h1);
      tick();
      check("t2_en", 32'(bank_en), 32'h9);
      idle();
      tick();
      tick();
      check("t2_a_rvalid", 32'(req.o_a_rvalid), 32'h1);
      check("t2_a_rdata",  32'(req.o_a_rdata),  32'h20);
      check("t2_b_rvalid", 32'(req.o_b_rvalid), 32'h1);
      check("t2_b_rdata",  32'(req.o_b_rdata),  32'hEF);
      tick();

      // Four held conflicting writes to bank sel 01: grants A, B, A, B.
      for (int c = 0; c < 5; c++) begin
         if (c < 4) begin
            drive_a(1'b1, 6'h10, 8'h11);
            drive_b(1'b1, 6'h11, 8'h22);
         end else begin
            idle();
         end
         #1;
         if (c < 4) begin
            check($sformatf("t3_a_ready_%0d", c), 32'(req.o_a_ready), (c % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("t3_b_ready_%0d", c), 32'(req.o_b_ready), (c % 2 == 0) ? 32'h0 : 32'h1);
         end
         if (c > 0) begin
            check($sformatf("t3_en_%0d", c),    32'(bank_en),           32'h4);
            check($sformatf("t3_addr_%0d", c),  32'(bank_addr[11:8]),   (c % 2 == 1) ? 32'h0 : 32'h1);
            check($sformatf("t3_wdata_%0d", c), 32'(bank_wdata[23:16]), (c % 2 == 1) ? 32'h11 : 32'h22);
         end
         tick();
      end
      check("t3_cnt", 32'(conflict_cnt), 32'h4);

      // Back-to-back A reads across all four banks: one result per cycle.
      for (int i = 0; i < 8; i++) begin
         if (i < 4) drive_a(1'b0, rr_addr[i], 8'h00);
         else       idle();
         #1;
         if (i < 4) check($sformatf("t4_ready_%0d", i), 32'(req.o_a_ready), 32'h1);
         if (i >= 3 && i < 7) begin
            check($sformatf("t4_rvalid_%0d", i), 32'(req.o_a_rvalid), 32'h1);
            check($sformatf("t4_rdata_%0d", i),  32'(req.o_a_rdata),  32'(rr_data[i-3]));
         end else begin
            check($sformatf("t4_rvalid_%0d", i), 32'(req.o_a_rvalid), 32'h0);
         end
         tick();
      end

      // Reset while a read is in flight, with priority pointing at B.
      drive_a(1'b0, 6'h05, 8'h00);
      drive_b(1'b0, 6'h06, 8'h00);
      #1;
      check("t5_a_ready", 32'(req.o_a_ready), 32'h1);
      check("t5_b_ready", 32'(req.o_b_ready), 32'h0);
      tick();
      check("t5_prio_b_a_ready", 32'(req.o_a_ready), 32'h0);
      check("t5_prio_b_b_ready", 32'(req.o_b_ready), 32'h1);
      check("t5_en", 32'(bank_en), 32'h8);
      idle();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("t5_no_rvalid_%0d", i), 32'(req.o_a_rvalid), 32'h0);
         check($sformatf("t5_rdata_%0d", i),     32'(req.o_a_rdata),  32'h0);
      end
      drive_a(1'b0, 6'h20, 8'h00);
      drive_b(1'b0, 6'h21, 8'h00);
      #1;
      check("t5_prio_a_a_ready", 32'(req.o_a_ready), 32'h1);
      check("t5_prio_a_b_ready", 32'(req.o_b_ready), 32'h0);
      idle();
      tick();

      // Sustained conflicts saturate the 4-bit counter at 4'hF.
      drive_a(1'b1, 6'h30, 8'h01);
      drive_b(1'b1, 6'h31, 8'h02);
      for (int i = 0; i < 14; i++) tick();
      check("t6_cnt_14", 32'(conflict_cnt), 32'hE);
      tick();
      check("t6_cnt_15", 32'(conflict_cnt), 32'hF);
      tick();
      tick();
      check("t6_cnt_sat", 32'(conflict_cnt), 32'hF);
      idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
